// File: rtl/mux_nx1_scan.sv
// N:1, W-bit multiplexer with a registered valid/ready output stage.
// MANUAL forwards the channel on sel; SCAN walks channels round-robin with a dwell timeout.
module mux_nx1_scan #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int SW    = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  cur_ch,
  output logic [N-1:0]   in_ack
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0] N_LIM = (SW + 1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic {MAN, SCAN} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   ptr_reg, ptr_next, ptr_inc;
  logic [DW-1:0]   dwell_reg, dwell_next;
  logic [W-1:0]    out_data_reg;
  logic            out_valid_reg;
  logic [SW-1:0]   cur_ch_reg;
  logic            load, sel_ok, cap;
  logic [SW-1:0]   cap_ch;
  logic [W-1:0]    ch [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_split
    assign ch[gi] = in_data[gi*W +: W];
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    dwell_next = dwell_reg;
    cap        = 1'b0;
    cap_ch     = ptr_reg;
    load       = !out_valid_reg || out_ready;
    sel_ok     = {1'b0, sel} < N_LIM;
    ptr_inc    = (ptr_reg == LAST_CH) ? '0 : ptr_reg + 1'b1;
    if (load) begin
      case (state_reg)
        MAN: begin
          // The entry cycle only loads the start pointer; scanning begins next cycle.
          if (mode) begin
            state_next = SCAN;
            ptr_next   = sel_ok ? sel : '0;
            dwell_next = '0;
          end else if (sel_ok && in_valid[sel]) begin
            cap    = 1'b1;
            cap_ch = sel;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_next = MAN;
          end else if (in_valid[ptr_reg]) begin
            cap        = 1'b1;
            cap_ch     = ptr_reg;
            ptr_next   = ptr_inc;
            dwell_next = '0;
          end else if (dwell_reg == DWELL_LAST) begin
            ptr_next   = ptr_inc;
            dwell_next = '0;
          end else begin
            dwell_next = dwell_reg + 1'b1;
          end
        end
        default: state_next = MAN;
      endcase
    end
    // Gate with rst_n so no word is acknowledged while it is being dropped.
    in_ack = (cap && rst_n) ? (N'(1) << cap_ch) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= MAN;
      ptr_reg       <= '0;
      dwell_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      cur_ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      dwell_reg <= dwell_next;
      if (load) begin
        out_valid_reg <= cap;
        if (cap) begin
          out_data_reg <= ch[cap_ch];
          cur_ch_reg   <= cap_ch;
        end
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign cur_ch    = cur_ch_reg;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Randomized scoreboard bench for mux_nx1_scan: an N=8 instance checked against a
// behavioural model, plus an N=5 instance for out-of-range select and odd wrap.
module tb_mux_nx1_scan;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [63:0] in_data_a = '0;
  logic [7:0]  in_valid_a = '0;
  logic        mode_a = 1'b0;
  logic [2:0]  sel_a = '0;
  logic        out_ready_a = 1'b0;
  logic [7:0]  out_data_a;
  logic        out_valid_a;
  logic [2:0]  cur_ch_a;
  logic [7:0]  in_ack_a;

  logic [39:0] in_data_b = '0;
  logic [4:0]  in_valid_b = '0;
  logic        mode_b = 1'b0;
  logic [2:0]  sel_b = '0;
  logic        out_ready_b = 1'b1;
  logic [7:0]  out_data_b;
  logic        out_valid_b;
  logic [2:0]  cur_ch_b;
  logic [4:0]  in_ack_b;

  always #5 clk = ~clk;

  mux_nx1_scan #(.N(8), .W(8), .DWELL(DWELL)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .mode(mode_a), .sel(sel_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .cur_ch(cur_ch_a), .in_ack(in_ack_a)
  );

  mux_nx1_scan #(.N(5), .W(8), .DWELL(DWELL)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
    .mode(mode_b), .sel(sel_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .cur_ch(cur_ch_b), .in_ack(in_ack_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [10:0] exp_q [$];

  // Behavioural view of the N=8 block: which mode it is in, where the scan
  // pointer sits, how long it has waited there, and whether a word is pending.
  bit m_scan = 0;
  int m_ptr = 0;
  int m_wait = 0;
  bit m_pending = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_ptr = 0; m_wait = 0; m_pending = 0;
    exp_q.delete();
  endtask

  // One clock cycle of stimulus on the N=8 instance; predicts in_ack now and
  // queues the word that should appear on the output one cycle later.
  task automatic cycle8(input bit mode, input logic [2:0] sel, input logic [7:0] valid,
                        input logic [63:0] data, input bit ready);
    bit take;
    bit cap;
    int chn;
    logic [7:0] exp_ack;
    logic [63:0] d;
    @(negedge clk);
    mode_a = mode; sel_a = sel; in_valid_a = valid; in_data_a = data; out_ready_a = ready;
    #1;
    take = !m_pending || ready;
    cap = 0;
    chn = 0;
    if (take) begin
      if (!m_scan) begin
        if (mode) begin
          m_scan = 1; m_ptr = int'(sel); m_wait = 0;
        end else if (valid[sel]) begin
          cap = 1; chn = int'(sel);
        end
      end else if (!mode) begin
        m_scan = 0;
      end else if (valid[m_ptr]) begin
        cap = 1; chn = m_ptr;
        m_ptr = (m_ptr + 1) % 8; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == DWELL) begin
          m_wait = 0; m_ptr = (m_ptr + 1) % 8;
        end
      end
      m_pending = cap;
    end
    exp_ack = cap ? (8'd1 << chn) : 8'd0;
    check("in_ack", {56'd0, in_ack_a}, {56'd0, exp_ack});
    if (cap) begin
      d = data >> (chn * 8);
      exp_q.push_back({3'(chn), d[7:0]});
    end
  endtask

  // Monitor: a fresh word is on the output whenever the previous cycle could load;
  // otherwise the stalled word must not move.
  initial begin
    forever begin
      automatic logic ld;
      automatic logic [7:0] prev_data;
      automatic logic [2:0] prev_ch;
      automatic logic [10:0] e;
      @(posedge clk);
      ld = !out_valid_a || out_ready_a;
      prev_data = out_data_a;
      prev_ch = cur_ch_a;
      #1;
      if (mon_en && rst_n) begin
        if (ld && out_valid_a) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {56'd0, out_data_a}, 64'hdead);
          end else begin
            e = exp_q.pop_front();
            check("word_data", {56'd0, out_data_a}, {56'd0, e[7:0]});
            check("word_ch", {61'd0, cur_ch_a}, {61'd0, e[10:8]});
          end
        end else if (!ld) begin
          check("hold_valid", {63'd0, out_valid_a}, 64'd1);
          check("hold_data", {56'd0, out_data_a}, {56'd0, prev_data});
          check("hold_ch", {61'd0, cur_ch_a}, {61'd0, prev_ch});
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    logic [39:0] db;
    bit rmode;

    // Reset state
    #12;
    check("rst_valid", {63'd0, out_valid_a}, 64'd0);
    check("rst_data", {56'd0, out_data_a}, 64'd0);
    check("rst_ch", {61'd0, cur_ch_a}, 64'd0);
    check("rst_ack", {56'd0, in_ack_a}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // MAN sel=5, ch5=A5
    d = '0; d[47:40] = 8'hA5;
    cycle8(0, 3'd5, 8'h20, d, 1);
    cycle8(0, 3'd5, 8'h00, d, 1);

    // MAN capture of ch2=3C, then stall three cycles with a new ch2 word waiting
    d = '0; d[23:16] = 8'h3C;
    cycle8(0, 3'd2, 8'h04, d, 0);
    d[23:16] = 8'h77;
    for (int i = 0; i < 3; i++) cycle8(0, 3'd2, 8'h04, d, 0);
    cycle8(0, 3'd2, 8'h04, d, 1);
    cycle8(0, 3'd2, 8'h00, d, 1);

    // SCAN from sel=6, every channel valid: 6,7,0,1,...
    for (int i = 0; i < 11; i++) cycle8(1, 3'd6, 8'hFF, {$urandom, $urandom}, 1);
    cycle8(0, 3'd0, 8'h00, '0, 1);

    // SCAN from 0, only ch3 valid: three full dwell periods, then ch3
    for (int i = 0; i < 15; i++) cycle8(1, 3'd0, 8'h08, {$urandom, $urandom}, 1);
    cycle8(0, 3'd0, 8'h00, '0, 1);

    // Randomized traffic with occasional mode flips and back-pressure
    rmode = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) rmode = !rmode;
      cycle8(rmode, 3'($urandom), 8'($urandom & $urandom), {$urandom, $urandom},
             $urandom_range(0, 3) != 0);
    end

    // Drain to MAN/idle, then get a SCAN word stalled and reset mid-cycle
    cycle8(0, 3'd0, 8'h00, '0, 1);
    cycle8(0, 3'd0, 8'h00, '0, 1);
    cycle8(1, 3'd3, 8'hFF, {$urandom, $urandom}, 1);
    cycle8(1, 3'd3, 8'hFF, {$urandom, $urandom}, 0);
    @(posedge clk);
    #3;
    check("pre_rst_valid", {63'd0, out_valid_a}, 64'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid_a}, 64'd0);
    check("arst_data", {56'd0, out_data_a}, 64'd0);
    check("arst_ch", {61'd0, cur_ch_a}, 64'd0);
    check("arst_ack", {56'd0, in_ack_a}, 64'd0);
    mode_a = 1'b0; in_valid_a = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    // MAN must capture immediately after release (a SCAN leftover would not)
    d = '0; d[15:8] = 8'h5A;
    cycle8(0, 3'd1, 8'h02, d, 1);
    cycle8(0, 3'd1, 8'h00, d, 1);
    cycle8(0, 3'd1, 8'h00, d, 1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // N=5 instance: sel=6 out of range in MAN never captures
    for (int k = 0; k < 5; k++) db[k*8 +: 8] = 8'h10 + 8'(k);
    @(negedge clk);
    in_data_b = db; in_valid_b = 5'h1F; sel_b = 3'd6; mode_b = 1'b0; out_ready_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("n5_man_ack", {59'd0, in_ack_b}, 64'd0);
      @(posedge clk);
      #1;
      check("n5_man_valid", {63'd0, out_valid_b}, 64'd0);
      @(negedge clk);
    end
    // SCAN entry with out-of-range sel starts at channel 0 and wraps 4 -> 0
    mode_b = 1'b1;
    @(posedge clk);
    #1;
    check("n5_entry_valid", {63'd0, out_valid_b}, 64'd0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      check("n5_scan_valid", {63'd0, out_valid_b}, 64'd1);
      check("n5_scan_ch", {61'd0, cur_ch_b}, 64'(i % 5));
      check("n5_scan_data", {56'd0, out_data_b}, 64'(8'h10 + 8'(i % 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
